// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//
// Shares one single-port 32x16 data memory between the two memory lanes of
// the dual-issue pipeline. Lane 0 carries the older instruction of an issue
// pair. When both lanes request in the same cycle, lane 0 goes first and
// lane 1 is owed the very next slot. Memory accesses therefore retire in
// program order, and lane 1 cannot be starved by a stream of lane-0 requests.
//
// Pipeline:  grant (T) -> memory access (T+1) -> writeback response (T+2).
//
// Ports
//   clk                      system clock, rising edge
//   rst_n                    synchronous, active-low reset
//   req_valid[1:0]           per-lane request, held until granted
//   req_isst[1:0]            per-lane 1 = store, 0 = load
//   req_addr0/1   [15:0]     word address (ALU result); only [4:0] is used,
//                            and any set bit in [15:5] is out of range
//   req_wdata0/1  [15:0]     store data
//   req_rd0/1     [2:0]      destination register
//   grant[1:0]               combinational, one-hot or zero
//   stall                    combinational, a valid lane was not granted
//   mem_en/mem_we            registered memory enable / write enable
//   mem_addr      [4:0]      registered word address
//   mem_wdata     [15:0]     registered write data (0 for loads)
//   mem_rdata     [15:0]     synchronous read data, one cycle after mem_en
//   resp_valid/resp_lane     writeback word valid / owning lane
//   resp_rdval    [19:0]     {store_flag, load data, rd}
//   addr_err                 out-of-range access, aligned with resp_valid
// ---------------------------------------------------------------------------
module dmem_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid,
    input  logic [1:0]  req_isst,
    input  logic [15:0] req_addr0,
    input  logic [15:0] req_addr1,
    input  logic [15:0] req_wdata0,
    input  logic [15:0] req_wdata1,
    input  logic [2:0]  req_rd0,
    input  logic [2:0]  req_rd1,
    output logic [1:0]  grant,
    output logic        stall,
    output logic        mem_en,
    output logic        mem_we,
    output logic [4:0]  mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic        resp_valid,
    output logic        resp_lane,
    output logic [19:0] resp_rdval,
    output logic        addr_err
);

    // -----------------------------------------------------------------------
    // Types
    // -----------------------------------------------------------------------
    typedef enum logic {
        FAIR = 1'b0,   // lane 0 has priority
        OWE1 = 1'b1    // lane 1 was denied last cycle and goes first now
    } arb_state_t;

    // Side-band tags that travel alongside the memory access so the
    // response can be assembled when the read data returns.
    typedef struct packed {
        logic       valid;
        logic       lane;
        logic       isst;
        logic       err;
        logic [2:0] rd;
    } tag_t;

    // -----------------------------------------------------------------------
    // Per-lane request decode
    // -----------------------------------------------------------------------
    logic [15:0] lane_addr  [2];
    logic [15:0] lane_wdata [2];
    logic [2:0]  lane_rd    [2];
    logic [1:0]  lane_in_range;

    assign lane_addr[0]  = req_addr0;
    assign lane_addr[1]  = req_addr1;
    assign lane_wdata[0] = req_wdata0;
    assign lane_wdata[1] = req_wdata1;
    assign lane_rd[0]    = req_rd0;
    assign lane_rd[1]    = req_rd1;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            // The memory holds 32 words; any upper address bit means the
            // access falls outside it and must not touch the array.
            assign lane_in_range[gi] = ~|lane_addr[gi][15:5];
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Arbitration FSM
    // -----------------------------------------------------------------------
    arb_state_t state_reg;
    arb_state_t state_next;
    logic [1:0] grant_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= FAIR;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        grant_next = 2'b00;
        // Grants are held off entirely while reset is asserted.
        if (rst_n) begin
            case (state_reg)
                FAIR: begin
                    grant_next[0] = req_valid[0];
                    grant_next[1] = req_valid[1] & ~req_valid[0];
                    if (&req_valid) begin
                        state_next = OWE1;
                    end
                end
                OWE1: begin
                    grant_next[1] = req_valid[1];
                    grant_next[0] = req_valid[0] & ~req_valid[1];
                    // Either lane 1 is served now, or it dropped its owed
                    // request (a protocol violation that is simply
                    // discarded). Both cases settle the debt.
                    state_next = FAIR;
                end
                default: begin
                    state_next = FAIR;
                end
            endcase
        end
    end

    assign grant = grant_next;
    assign stall = rst_n & (|(req_valid & ~grant_next));

    // -----------------------------------------------------------------------
    // Selected request (grant is one-hot, so grant[1] names the lane)
    // -----------------------------------------------------------------------
    logic        any_grant;
    logic        sel_lane;
    logic        sel_isst;
    logic        sel_in_range;
    logic [4:0]  sel_waddr;
    logic [15:0] sel_wdata;
    logic [2:0]  sel_rd;
    logic        sel_access;

    assign any_grant    = |grant_next;
    assign sel_lane     = grant_next[1];
    assign sel_isst     = req_isst[sel_lane];
    assign sel_in_range = lane_in_range[sel_lane];
    assign sel_waddr    = lane_addr[sel_lane][4:0];
    assign sel_wdata    = lane_wdata[sel_lane];
    assign sel_rd       = lane_rd[sel_lane];
    assign sel_access   = any_grant & sel_in_range;

    // -----------------------------------------------------------------------
    // Memory stage (T+1)
    // -----------------------------------------------------------------------
    logic        mem_en_reg;
    logic        mem_we_reg;
    logic [4:0]  mem_addr_reg;
    logic [15:0] mem_wdata_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_en_reg    <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= 5'd0;
            mem_wdata_reg <= 16'h0000;
        end else begin
            mem_en_reg <= sel_access;
            mem_we_reg <= sel_access & sel_isst;
            // Address and data only move on a real access, so idle and
            // suppressed slots leave the bus quiet.
            if (sel_access) begin
                mem_addr_reg  <= sel_waddr;
                mem_wdata_reg <= sel_isst ? sel_wdata : 16'h0000;
            end
        end
    end

    assign mem_en    = mem_en_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;

    // -----------------------------------------------------------------------
    // Two-stage tag shift pipeline (T+1, T+2)
    // -----------------------------------------------------------------------
    tag_t tag_in;
    tag_t tag_reg [2];

    always_comb begin
        tag_in       = '0;
        tag_in.valid = any_grant;
        tag_in.lane  = sel_lane;
        tag_in.isst  = any_grant & sel_isst;
        tag_in.err   = any_grant & ~sel_in_range;
        tag_in.rd    = any_grant ? sel_rd : 3'd0;
    end

    // Reset clears both stages, so anything granted before reset never
    // produces a response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tag_reg[0] <= '0;
            tag_reg[1] <= '0;
        end else begin
            tag_reg[0] <= tag_in;
            tag_reg[1] <= tag_reg[0];
        end
    end

    // -----------------------------------------------------------------------
    // Response (T+2). mem_rdata arrives this cycle for a load issued at T+1,
    // so the writeback word is assembled combinationally from it and the
    // registered tags.
    // -----------------------------------------------------------------------
    always_comb begin
        resp_rdval = 20'h00000;
        if (tag_reg[1].valid) begin
            if (tag_reg[1].isst) begin
                resp_rdval = {1'b1, 16'h0000, 3'd0};
            end else if (tag_reg[1].err) begin
                resp_rdval = {1'b0, 16'h0000, tag_reg[1].rd};
            end else begin
                resp_rdval = {1'b0, mem_rdata, tag_reg[1].rd};
            end
        end
    end

    assign resp_valid = tag_reg[1].valid;
    assign resp_lane  = tag_reg[1].lane;
    assign addr_err   = tag_reg[1].valid & tag_reg[1].err;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

- Shares the single-port 32x16 data memory between the two memory lanes of the dual-issue pipeline.
- Lane 0 always holds the older instruction of an issue pair. A lane-1 request deferred behind lane 0 is owed the next slot, so memory accesses retire in program order.
- Each lane gets a 20-bit writeback word in the memory-stage format: {store_flag, data[15:0], rd[2:0]}.

## Interface

- No parameters. Memory depth is 32 words and word width is 16 bits, both fixed.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid[1:0]  in  2  per-lane memory request. Must be held stable until granted.
- req_isst[1:0]  in  2  per-lane: 1 = store, 0 = load.
- req_addr0, req_addr1  in  16 each  ALU result used as the byte-free word address.
- req_wdata0, req_wdata1  in  16 each  store data (op2).
- req_rd0, req_rd1  in  3 each  destination register (instr[7:5]).
- grant[1:0]  out  2  combinational; asserted in the cycle a request is accepted.
- stall  out  1  combinational; set when any valid lane is not granted this cycle.
- mem_en  out  1  registered memory enable.
- mem_we  out  1  registered write enable.
- mem_addr  out  5  registered word address.
- mem_wdata  out  16  registered write data.
- mem_rdata  in  16  synchronous read data, valid one cycle after mem_en.
- resp_valid  out  1  writeback word valid.
- resp_lane  out  1  lane that owns the response.
- resp_rdval  out  20  {isst, load data or 0, rd or 0}.
- addr_err  out  1  one-cycle pulse, aligned with resp_valid, for an out-of-range access.

## Operation

- FSM has 2 states: FAIR and OWE1.
  - FAIR: lane 0 has priority. grant0 = req_valid[0]. grant1 = req_valid[1] & ~req_valid[0].
  - FAIR -> OWE1: when both lanes are valid (lane 1 is denied).
  - OWE1: lane 1 has priority. grant1 = req_valid[1]. grant0 = req_valid[0] & ~req_valid[1].
  - OWE1 -> FAIR: when lane 1 is granted, or when req_valid[1] is low. A dropped owed request is a protocol violation and is discarded.
- At most one grant per cycle. grant is never asserted on an invalid lane.
- stall = |(req_valid & ~grant).
- Address: the access uses req_addr[4:0].
  - If req_addr[15:5] != 0, the access is suppressed: mem_en = 0 for that slot.
  - A suppressed load returns data 0. A suppressed store writes nothing.
  - In both cases addr_err pulses with the response.
- Accepted access, cycle T+1:
  - mem_en = 1, mem_we = isst, mem_addr = addr[4:0].
  - mem_wdata = wdata for a store, 0 for a load.
- Response, cycle T+2: resp_valid = 1, resp_lane = the granted lane.
  - Load: resp_rdval = {1'b0, mem_rdata, rd}.
  - Store: resp_rdval = {1'b1, 16'h0, 3'h0}.
  - Out-of-range load: resp_rdval = {1'b0, 16'h0, rd}.
- The lane, isst, rd and error tags are carried in a 2-stage shift pipeline alongside the memory access.
- Same-address store (lane 0) and load (lane 1) in one pair: the store is issued first, so the load observes the new value. This relies on the memory's write-then-read ordering across cycles.
- Throughput is 1 access per cycle. Back-to-back grants are allowed with no bubbles.

## Timing

- Reset (rst_n low at a clock edge):
  - State = FAIR.
  - mem_en, mem_we, resp_valid and addr_err = 0.
  - mem_addr = 0, mem_wdata = 0, resp_lane = 0, resp_rdval = 0.
  - In-flight accesses are discarded: no response is produced for requests granted before reset.
  - grant and stall are combinational, but both are forced to 0 while rst_n is low.
- Latency: grant at T, memory access at T+1, response at T+2.
- While both lanes are valid, grants alternate 0,1,0,1... This stops new lane-0 requests from starving lane 1.
- Idle cycles (no grant) produce mem_en = 0 at T+1 and resp_valid = 0 at T+2. mem_addr and mem_wdata hold their previous values.

## Test plan

- Single load: memory word 3 = 16'hBEEF. Lane 0 loads addr 3 with rd 5. Expect grant0 at T, mem_en = 1 / mem_we = 0 / mem_addr = 3 at T+1, and resp_rdval = 20'h5F77D (= {0, BEEF, 101}) with resp_lane = 0 at T+2.
- Pair conflict: lane 0 stores 16'h1234 to addr 7 and lane 1 loads addr 7 (rd 2), in the same cycle.
  - T: grant = 01, stall = 1.
  - T+1: grant = 10.
  - T+2: response is 20'h80000 (store flag set, lane 0).
  - T+3: response is 20'h091A2 (= {0, 1234, 010}), lane 1.
- Fairness: lane 0 and lane 1 are both valid for 6 consecutive cycles, each presenting a new request after every grant. Expect the grant sequence 01,10,01,10,01,10 with no grant ever 11.
- Out of range: lane 1 loads addr 16'h0025 with rd 1. Expect mem_en = 0 at T+1, then at T+2 resp_valid = 1, addr_err = 1 and resp_rdval = 20'h00001.
- Reset mid-flight: grant a load at T, then pull rst_n low at the T+1 edge. Expect resp_valid = 0 at T+2, state FAIR, and all registered outputs 0.
- Owed drop: create the OWE1 state, then deassert req_valid[1]. Expect a return to FAIR and lane 0 granted on its next request.
